// File: rtl/divider_pkg.sv
// Shared constants, state type and iteration-count helper for the restoring divider control unit.
package divider_pkg;

   localparam int unsigned DIV_WIDTH = 10;
   localparam int unsigned DIV_FRAC  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      CHECK  = 3'd2,
      SHIFT  = 3'd3,
      UPDATE = 3'd4,
      DONE   = 3'd5
   } div_state_t;

   // One shift/subtract iteration per integer and fractional quotient bit.
   function automatic int unsigned div_iter(input int unsigned width, input int unsigned frac);
      return width + frac;
   endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: cleared at INIT, advanced once per UPDATE, saturates at ITER-1.
module div_iter_counter #(
   parameter int unsigned ITER  = 14,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o,
   output logic             last_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             last_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !last_q) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // last is registered alongside the count so it is glitch-free in UPDATE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         last_q  <= 1'(ITER == 1);
      end else begin
         count_q <= count_d;
         last_q  <= (count_d == CNT_W'(ITER - 1));
      end
   end

   assign count_o = count_q;
   assign last_o  = last_q;

endmodule

// File: rtl/divider_controller.sv
// Control FSM of the unsigned fixed-point restoring divider: sequences the A/Q/B datapath
// strobes, runs the start/busy/valid handshake and flags divide-by-zero and quotient overflow.
module divider_controller
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned FRAC  = DIV_FRAC
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic b_is_zero_i,
   input  logic a_ge_b_i,
   input  logic q_msb_i,
   output logic a_load_o,
   output logic a_clr_o,
   output logic a_shl_o,
   output logic q_load_o,
   output logic q_shl_o,
   output logic q_set0_o,
   output logic b_load_o,
   output logic busy_o,
   output logic valid_o,
   output logic dvz_o,
   output logic ovf_o
);

   localparam int unsigned ITER  = div_iter(WIDTH, FRAC);
   localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

   localparam logic [2:0] ST_IDLE   = 3'(IDLE);
   localparam logic [2:0] ST_INIT   = 3'(INIT);
   localparam logic [2:0] ST_CHECK  = 3'(CHECK);
   localparam logic [2:0] ST_SHIFT  = 3'(SHIFT);
   localparam logic [2:0] ST_UPDATE = 3'(UPDATE);
   localparam logic [2:0] ST_DONE   = 3'(DONE);

   logic [2:0]       state_q, state_d;
   logic             dvz_q, dvz_d;
   logic             ovf_q, ovf_d;
   logic             init_q, init_d;
   logic             shift_q, shift_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;

   div_iter_counter #(
      .ITER  (ITER),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (state_q == ST_INIT),
      .inc_i   (state_q == ST_UPDATE),
      .count_o (cnt),
      .last_o  (cnt_last)
   );

   // Next state and sticky flags; Moore strobes are decoded from the next state so they leave a flop.
   always_comb begin
      state_d = state_q;
      dvz_d   = dvz_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_INIT;
         end
         ST_INIT: begin
            dvz_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (b_is_zero_i) begin
               dvz_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A one leaving Q after the integer bits means the quotient does not fit.
            if ((32'(cnt) >= WIDTH) && q_msb_i) ovf_d = 1'b1;
            state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            state_d = cnt_last ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      init_d  = (state_d == ST_INIT);
      shift_d = (state_d == ST_SHIFT);
      busy_d  = (state_d != ST_IDLE);
      valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         dvz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         init_q  <= 1'b0;
         shift_q <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dvz_q   <= dvz_d;
         ovf_q   <= ovf_d;
         init_q  <= init_d;
         shift_q <= shift_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign a_clr_o  = init_q;
   assign b_load_o = init_q;
   assign q_load_o = init_q;
   assign a_shl_o  = shift_q;
   assign q_shl_o  = shift_q;
   assign busy_o   = busy_q;
   assign valid_o  = valid_q;
   assign dvz_o    = dvz_q;
   assign ovf_o    = ovf_q;

   // Restore step depends on the live comparator result, so these two follow a_ge_b directly.
   assign a_load_o = (state_q == ST_UPDATE) && a_ge_b_i;
   assign q_set0_o = (state_q == ST_UPDATE) && a_ge_b_i;

endmodule

// File: tb/tb_divider_controller.sv
// Self-checking bench for divider_controller: cycle-position model of a run plus directed scenarios.
module tb_divider_controller;

   localparam int WIDTH = 10;
   localparam int FRAC  = 4;
   localparam int ITER  = WIDTH + FRAC;
   localparam int KDONE = 2 + 2 * ITER;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic b_is_zero = 1'b0;
   logic a_ge_b = 1'b0;
   logic q_msb = 1'b0;
   logic a_load, a_clr, a_shl, q_load, q_shl, q_set0, b_load, busy, valid, dvz, ovf;

   divider_controller dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .b_is_zero_i (b_is_zero),
      .a_ge_b_i    (a_ge_b),
      .q_msb_i     (q_msb),
      .a_load_o    (a_load),
      .a_clr_o     (a_clr),
      .a_shl_o     (a_shl),
      .q_load_o    (q_load),
      .q_shl_o     (q_shl),
      .q_set0_o    (q_set0),
      .b_load_o    (b_load),
      .busy_o      (busy),
      .valid_o     (valid),
      .dvz_o       (dvz),
      .ovf_o       (ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: position k within a run (0 = INIT, 1 = CHECK, even k>=2 shift, odd update, KDONE result).
   bit   run = 0;
   int   k = 0;
   bit   dvz_m = 0;
   bit   ovf_m = 0;
   int   ecount = 0;
   int   start_edge = 0;

   always @(posedge clk) begin
      ecount++;
      if (!rst_n) begin
         run = 0; k = 0; dvz_m = 0; ovf_m = 0;
      end else if (!run) begin
         if (start) begin run = 1; k = 0; start_edge = ecount; end
      end else if (k == KDONE) begin
         run = 0;
      end else if (k == 0) begin
         dvz_m = 0; ovf_m = 0; k = 1;
      end else if (k == 1) begin
         if (b_is_zero) begin dvz_m = 1; k = KDONE; end
         else k = 2;
      end else begin
         if ((k % 2 == 0) && ((k - 2) / 2 >= WIDTH) && q_msb) ovf_m = 1;
         k++;
      end
   end

   // Datapath stand-in: a_ge_b pattern and per-iteration q_msb mask.
   int          age_mode = 0;
   logic [13:0] qmsb_mask = '0;

   always @(posedge clk) begin
      #2;
      a_ge_b = (age_mode == 2) ? 1'($urandom % 2) : (age_mode == 1);
      q_msb  = (run && k >= 2 && k < KDONE && (k % 2 == 0)) ? qmsb_mask[(k - 2) / 2] : 1'b0;
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic e_busy, e_init, e_shift, e_upd;
      e_busy  = rst_n && run;
      e_init  = e_busy && (k == 0);
      e_shift = e_busy && (k >= 2) && (k < KDONE) && (k % 2 == 0);
      e_upd   = e_busy && (k >= 2) && (k < KDONE) && (k % 2 == 1);
      chk("busy",   busy,   e_busy);
      chk("valid",  valid,  e_busy && (k == KDONE));
      chk("a_clr",  a_clr,  e_init);
      chk("b_load", b_load, e_init);
      chk("q_load", q_load, e_init);
      chk("a_shl",  a_shl,  e_shift);
      chk("q_shl",  q_shl,  e_shift);
      chk("a_load", a_load, e_upd && a_ge_b);
      chk("q_set0", q_set0, e_upd && a_ge_b);
      chk("dvz",    dvz,    rst_n && dvz_m);
      chk("ovf",    ovf,    rst_n && ovf_m);
   end

   // Pulse and result monitor for the directed literal checks.
   int n_ashl, n_qshl, n_aload, n_qset, n_valid, n_overlap, lat;
   int v_edge [4];
   bit dvz_at_valid, ovf_at_valid;

   always @(negedge clk) begin
      if (rst_n) begin
         n_ashl    += int'(a_shl);
         n_qshl    += int'(q_shl);
         n_aload   += int'(a_load);
         n_qset    += int'(q_set0);
         n_overlap += int'((a_shl && a_load) || (q_shl && q_set0));
         if (valid) begin
            if (n_valid < 4) v_edge[n_valid] = ecount;
            n_valid++;
            lat          = ecount - start_edge;
            dvz_at_valid = dvz;
            ovf_at_valid = ovf;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_counts();
      n_ashl = 0; n_qshl = 0; n_aload = 0; n_qset = 0; n_valid = 0; n_overlap = 0; lat = -1;
   endtask

   // One run from a single start pulse; optional start noise while busy.
   task automatic run_once(input bit noise);
      bit seen;
      seen = 0;
      clear_counts();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         #1;
         if (noise) start = 1'((i % 3 == 1) && (i < 24));
         if (n_valid > 0) begin seen = 1; break; end
      end
      start = 1'b0;
      if (!seen) chk("valid_timeout", 0, 1);
      tick(1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_flags", {dvz, ovf}, 0);
      tick(2);

      // Normal run with random comparator results and start noise while busy.
      age_mode = 2; qmsb_mask = '0;
      run_once(1);
      chk("n_a_shl", n_ashl, 14);
      chk("n_q_shl", n_qshl, 14);
      chk("latency", lat, 30);
      chk("n_valid", n_valid, 1);
      chk("idle_busy", busy, 0);
      chk("ovf_none", ovf_at_valid, 0);
      chk("overlap", n_overlap, 0);
      tick(2);

      age_mode = 1;
      run_once(0);
      chk("n_a_load_ge", n_aload, 14);
      chk("n_q_set0_ge", n_qset, 14);
      chk("overlap_ge", n_overlap, 0);
      age_mode = 0;
      run_once(0);
      chk("n_a_load_lt", n_aload, 0);
      chk("n_q_set0_lt", n_qset, 0);

      // Divide by zero.
      b_is_zero = 1'b1;
      run_once(0);
      b_is_zero = 1'b0;
      chk("dvz_latency", lat, 2);
      chk("dvz_flag", dvz_at_valid, 1);
      chk("dvz_no_shift", n_ashl, 0);
      tick(2);
      chk("dvz_hold", dvz, 1);

      // Overflow detection on the first fractional iteration, and none in integer iterations.
      qmsb_mask = 14'(1 << 10);
      run_once(0);
      chk("ovf_iter10", ovf_at_valid, 1);
      chk("ovf_clears_dvz", dvz_at_valid, 0);
      tick(2);
      chk("ovf_hold", ovf, 1);
      qmsb_mask = 14'h3FF;
      run_once(0);
      chk("ovf_int_only", ovf_at_valid, 0);
      qmsb_mask = 14'(1 << 13);
      run_once(0);
      chk("ovf_iter13", ovf_at_valid, 1);
      qmsb_mask = '0;

      // Start held high: back-to-back runs with one IDLE cycle in between.
      clear_counts();
      age_mode = 2;
      start = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (n_valid >= 2) break;
      end
      start = 1'b0;
      chk("b2b_valid_cnt", n_valid, 2);
      chk("b2b_gap", v_edge[1] - v_edge[0], 32);
      chk("b2b_latency", lat, 30);
      tick(3);
      chk("b2b_stop", busy, 0);

      // Asynchronous reset in the middle of an UPDATE cycle.
      age_mode = 1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (run && k == 5) break;
         tick(1);
      end
      chk("upd_reached", a_load, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_aload", a_load, 0);
      chk("rst_mid_qset0", q_set0, 0);
      chk("rst_mid_strobes", {a_clr, a_shl, q_load, q_shl, b_load, valid}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("rst_mid_idle", busy, 0);
      age_mode = 0;
      run_once(0);
      chk("after_rst_latency", lat, 30);

      tick(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
